instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 59 +++++
 rtl/instr_fetch_imem.sv | 26 ++
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit and the cpu it feeds:
// FSM state type, opcodes, condition codes, instruction field positions,
// PSR bit indices and the branch-condition evaluator.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_EXEC,
    ST_RETIRE,
    ST_HALT
  } fetch_state_e;

  // Opcodes
  localparam logic [3:0] OP_BRA = 4'h3;
  localparam logic [3:0] OP_HLT = 4'h8;

  // Condition codes
  localparam logic [3:0] CC_ALWAYS  = 4'h0;
  localparam logic [3:0] CC_PARITY  = 4'h1;
  localparam logic [3:0] CC_EVEN    = 4'h2;
  localparam logic [3:0] CC_CARRY   = 4'h3;
  localparam logic [3:0] CC_NEG     = 4'h4;
  localparam logic [3:0] CC_ZERO    = 4'h5;
  localparam logic [3:0] CC_NCARRY  = 4'h6;
  localparam logic [3:0] CC_NNEG    = 4'h7;

  // Instruction field positions
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned CC_LSB  = 24;
  localparam int unsigned TGT_LSB = 0;

  // PSR bit indices
  localparam int unsigned PSR_CARRY  = 0;
  localparam int unsigned PSR_PARITY = 1;
  localparam int unsigned PSR_EVEN   = 2;
  localparam int unsigned PSR_NEG    = 3;
  localparam int unsigned PSR_ZERO   = 4;

  // Codes 8-15 are never taken.
  function automatic logic cond_met(input logic [3:0] cc, input logic [4:0] psr);
    logic r;
    r = 1'b0;
    case (cc)
      CC_ALWAYS: r = 1'b1;
      CC_PARITY: r = psr[PSR_PARITY];
      CC_EVEN:   r = psr[PSR_EVEN];
      CC_CARRY:  r = psr[PSR_CARRY];
      CC_NEG:    r = psr[PSR_NEG];
      CC_ZERO:   r = psr[PSR_ZERO];
      CC_NCARRY: r = ~psr[PSR_CARRY];
      CC_NNEG:   r = ~psr[PSR_NEG];
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_fetch_imem.sv
// Instruction store: 2**MINDW x IRW, one synchronous write port and one
// synchronous read port. Contents are not affected by reset.
//   clk   - clock
//   we    - write enable
//   waddr - write address, wdata - write word
//   raddr - read address, rdata - registered read word
module instr_fetch_imem #(
  parameter int IRW   = 32,
  parameter int MINDW = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [MINDW-1:0] waddr,
  input  logic [IRW-1:0]   wdata,
  input  logic [MINDW-1:0] raddr,
  output logic [IRW-1:0]   rdata
);

  logic [IRW-1:0] mem [2**MINDW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch unit: loads a program into imem, then sequences
// FETCH/ISSUE/EXEC/RETIRE per instruction, handing each word to the cpu for
// one cycle, taking flags back and branching or halting on retire.
//   clk, rst           - clock, synchronous active-high reset
//   start, StartAddr   - begin fetching at StartAddr (IDLE/HALT only)
//   ImemWe/Addr/Data   - program-load port (IDLE/HALT only)
//   IReg, IValid       - instruction to the cpu and its valid flag
//   PsrIn              - flags returned to the cpu
//   PsrOut, mutexLow   - flags and HLT release from the cpu, valid in RETIRE
//   Pc, Halted         - program counter and halt indication
//   InstrCount         - retired-instruction count
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int IRW   = 32,
  parameter int PSRW  = 5,
  parameter int MINDW = 12,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MINDW-1:0] StartAddr,
  input  logic             ImemWe,
  input  logic [MINDW-1:0] ImemAddr,
  input  logic [IRW-1:0]   ImemData,
  output logic [IRW-1:0]   IReg,
  output logic             IValid,
  output logic [PSRW-1:0]  PsrIn,
  input  logic [PSRW-1:0]  PsrOut,
  input  logic             mutexLow,
  output logic [MINDW-1:0] Pc,
  output logic             Halted,
  output logic [CNTW-1:0]  InstrCount
);

  fetch_state_e     state;
  logic [IRW-1:0]   rdata;
  logic             mem_we;
  // IReg is cleared before RETIRE, so the fields needed there are kept aside.
  logic [3:0]       cur_op;
  logic [3:0]       cur_cc;
  logic [MINDW-1:0] cur_tgt;

  assign mem_we = ImemWe && (state == ST_IDLE || state == ST_HALT);

  // Read address is always Pc; the word captured at the FETCH edge is used.
  instr_fetch_imem #(.IRW(IRW), .MINDW(MINDW)) imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ImemAddr),
    .wdata (ImemData),
    .raddr (Pc),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      IReg       <= '0;
      IValid     <= 1'b0;
      PsrIn      <= '0;
      Pc         <= '0;
      Halted     <= 1'b0;
      InstrCount <= '0;
      cur_op     <= '0;
      cur_cc     <= '0;
      cur_tgt    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            Pc     <= StartAddr;
            Halted <= 1'b0;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_ISSUE;
        ST_ISSUE: begin
          IReg    <= rdata;
          IValid  <= 1'b1;
          cur_op  <= rdata[OP_LSB +: 4];
          cur_cc  <= rdata[CC_LSB +: 4];
          cur_tgt <= rdata[TGT_LSB +: MINDW];
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          IReg   <= '0;
          IValid <= 1'b0;
          state  <= ST_RETIRE;
        end
        ST_RETIRE: begin
          PsrIn      <= PsrOut;
          InstrCount <= InstrCount + CNTW'(1);
          if (mutexLow) begin
            Halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            if (cur_op == OP_BRA && cond_met(cur_cc, PsrIn[4:0]))
              Pc <= cur_tgt;
            else
              Pc <= Pc + MINDW'(1);
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] StartAddr = '0;
  logic        ImemWe = 1'b0;
  logic [11:0] ImemAddr = '0;
  logic [31:0] ImemData = '0;
  logic [31:0] IReg;
  logic        IValid;
  logic [4:0]  PsrIn;
  logic [4:0]  PsrOut = '0;
  logic        mutexLow = 1'b0;
  logic [11:0] Pc;
  logic        Halted;
  logic [15:0] InstrCount;

  instr_fetch #(.IRW(32), .PSRW(5), .MINDW(12), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .StartAddr(StartAddr),
    .ImemWe(ImemWe), .ImemAddr(ImemAddr), .ImemData(ImemData),
    .IReg(IReg), .IValid(IValid), .PsrIn(PsrIn), .PsrOut(PsrOut),
    .mutexLow(mutexLow), .Pc(Pc), .Halted(Halted), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state (instruction-level)
  logic [31:0] mem_m [4096];
  logic [11:0] pc_m = '0;
  logic [4:0]  psr_m = '0;
  logic [15:0] count_m = '0;
  logic        halted_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Branch rule on flags: carry0 parity1 even2 negative3 zero4
  function automatic bit taken_m(input logic [3:0] cc, input logic [4:0] p);
    case (cc)
      4'd0: return 1'b1;
      4'd1: return p[1];
      4'd2: return p[2];
      4'd3: return p[0];
      4'd4: return p[3];
      4'd5: return p[4];
      4'd6: return !p[0];
      4'd7: return !p[3];
      default: return 1'b0;
    endcase
  endfunction

  task automatic load(input logic [11:0] a, input logic [31:0] d);
    ImemWe = 1'b1; ImemAddr = a; ImemData = d;
    @(negedge clk);
    ImemWe = 1'b0;
    mem_m[a] = d;
  endtask

  // Start at sa and play the cpu until halt. The cpu raises mutexLow on HLT
  // or on the max_instr-th instruction. junk: write imem and pulse start while
  // busy (both must be ignored). wr: program-load write at sa together with start.
  task automatic run(input logic [11:0] sa, input int max_instr, input bit junk,
                     input bit fix_psr, input logic [4:0] psr_val,
                     input bit wr, input logic [31:0] wdata);
    logic [31:0] instr;
    logic [4:0]  pout;
    bit          stop;
    bit          tk;
    int          w;
    start = 1'b1; StartAddr = sa;
    if (wr) begin
      ImemWe = 1'b1; ImemAddr = sa; ImemData = wdata; mem_m[sa] = wdata;
    end
    @(negedge clk);
    start = 1'b0; ImemWe = 1'b0;
    pc_m = sa; halted_m = 1'b0;
    check("start_pc", Pc, pc_m);
    check("start_halted", Halted, 0);
    for (int n = 0; n < max_instr; n++) begin
      w = 0;
      while (IValid !== 1'b1 && w < 8) begin
        @(negedge clk); w++;
        check("psr_hold", PsrIn, psr_m);
      end
      check("fetch_latency", w, 2);
      if (IValid !== 1'b1) return;
      instr = mem_m[pc_m];
      check("ireg", IReg, instr);
      stop = (instr[31:28] == 4'h8) || (n == max_instr - 1);
      pout = fix_psr ? psr_val : 5'($urandom);
      PsrOut = pout; mutexLow = stop;
      if (junk) begin
        ImemWe = 1'b1; ImemAddr = pc_m; ImemData = ~instr;
        start = 1'b1; StartAddr = ~sa;
      end
      @(negedge clk);
      check("ireg_clear", IReg, 0);
      check("ivalid_clear", IValid, 0);
      check("psr_hold_ret", PsrIn, psr_m);
      @(negedge clk);
      ImemWe = 1'b0; start = 1'b0; mutexLow = 1'b0;
      tk = (instr[31:28] == 4'h3) && taken_m(instr[27:24], psr_m);
      psr_m = pout;
      count_m = count_m + 16'd1;
      if (stop) halted_m = 1'b1;
      else pc_m = tk ? instr[11:0] : pc_m + 12'd1;
      check("pc", Pc, pc_m);
      check("psr", PsrIn, psr_m);
      check("count", InstrCount, count_m);
      check("halted", Halted, halted_m);
      if (halted_m) break;
    end
  endtask

  task automatic mid_reset(input logic [11:0] sa);
    int w;
    start = 1'b1; StartAddr = sa;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (IValid !== 1'b1 && w < 8) begin @(negedge clk); w++; end
    check("rst_reach_exec", IValid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pc_m = '0; psr_m = '0; count_m = '0; halted_m = 1'b0;
    check("rst_ireg", IReg, 0);
    check("rst_ivalid", IValid, 0);
    check("rst_psr", PsrIn, 0);
    check("rst_pc", Pc, 0);
    check("rst_halted", Halted, 0);
    check("rst_count", InstrCount, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ivalid", IValid, 0);
      check("idle_pc", Pc, 0);
    end
  endtask

  initial begin
    logic [11:0] base;
    logic [31:0] wd;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("init_ireg", IReg, 0);
    check("init_ivalid", IValid, 0);
    check("init_psr", PsrIn, 0);
    check("init_pc", Pc, 0);
    check("init_halted", Halted, 0);
    check("init_count", InstrCount, 0);

    // Two-instruction program ending in HLT; carry flag returned.
    load(12'h000, 32'h5000_0001);
    load(12'h001, 32'h8000_0000);
    run(12'h000, 8, 0, 1, 5'b00001, 0, '0);
    check("hlt_halted", Halted, 1);
    check("hlt_pc", Pc, 12'h001);
    check("hlt_count", InstrCount, 2);
    check("carry_psr", PsrIn, 5'b00001);

    // Branch on zero: set zero flag, then branch taken.
    load(12'h000, 32'h0000_0000);
    run(12'h000, 8, 0, 1, 5'b10000, 0, '0);
    load(12'h000, 32'h3500_0010);
    load(12'h010, 32'h8000_0000);
    run(12'h000, 8, 0, 1, 5'b00000, 0, '0);
    check("bra_taken_pc", Pc, 12'h010);
    // Zero flag now clear: not taken, falls through to HLT at 1.
    run(12'h000, 8, 0, 1, 5'b00000, 0, '0);
    check("bra_not_taken_pc", Pc, 12'h001);
    // CC=0xA with all flags set: never taken.
    load(12'h020, 32'h0000_0000);
    load(12'h021, 32'h8000_0000);
    run(12'h020, 8, 0, 1, 5'b11111, 0, '0);
    load(12'h000, 32'h3A00_0010);
    run(12'h000, 8, 0, 1, 5'b00000, 0, '0);
    check("cc_a_pc", Pc, 12'h001);

    // Pc wrap 0xFFF -> 0x000
    load(12'hFFF, 32'h1234_5678);
    load(12'h000, 32'h8000_0000);
    run(12'hFFF, 8, 0, 0, '0, 0, '0);
    check("wrap_pc", Pc, 12'h000);

    // Writes and start while busy are ignored; readback by re-running.
    load(12'h100, 32'h1111_1111);
    load(12'h101, 32'h2222_2222);
    load(12'h102, 32'h8000_0000);
    run(12'h100, 8, 1, 0, '0, 0, '0);
    run(12'h100, 8, 0, 0, '0, 0, '0);
    // Write in the same cycle as start: new word issued.
    run(12'h100, 8, 0, 0, '0, 1, 32'h4444_4444);

    // Randomized programs
    for (int t = 0; t < 8; t++) begin
      base = 12'($urandom_range(16'h200, 16'hF00));
      for (int k = 0; k < 8; k++) begin
        wd = $urandom;
        if (wd[31:28] == 4'h3) wd[11:0] = base + 12'($urandom_range(0, 7));
        load(base + 12'(k), wd);
      end
      load(base + 12'd8, 32'h8000_0000);
      run(base, 20, bit'($urandom_range(0, 1)), 0, '0, 0, '0);
    end

    // Reset mid-EXEC, then memory contents still present.
    mid_reset(12'h100);
    run(12'h100, 8, 0, 0, '0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
